// File: rtl/phys_reg_free_list_pkg.sv
// Shared configuration for the physical register free list.
// Project-wide register-file sizes; a global config may predefine these.
`ifndef PROJ_NUM_ARCH_REGS
`define PROJ_NUM_ARCH_REGS 32
`endif
`ifndef PROJ_NUM_PHYS_REGS
`define PROJ_NUM_PHYS_REGS 64
`endif

package phys_reg_free_list_pkg;
  localparam int DEF_NUM_ARCH_REGS = `PROJ_NUM_ARCH_REGS;
  localparam int DEF_NUM_PHYS_REGS = `PROJ_NUM_PHYS_REGS;
endpackage

// File: rtl/phys_reg_free_list_find_first_set.sv
// Lowest-set-bit finder: index of the least significant 1 in vec, plus valid.
module find_first_set #(
  parameter  int WIDTH = 64,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!valid && vec[i]) begin
        index = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list: free mask + count, lowest-index allocation,
// retire-time free, flush rebuild from the retirement RAT, sticky error flag.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
#(
  parameter  int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
  parameter  int NUM_PHYS_REGS = DEF_NUM_PHYS_REGS,
  localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     Alloc_req_IN,
  output logic                     Alloc_ready_OUT,
  output logic [LOG_PHYS-1:0]      Alloc_reg_OUT,
  input  logic                     Free_valid_IN,
  input  logic [LOG_PHYS-1:0]      Free_reg_IN,
  input  logic                     Flush_IN,
  input  logic [NUM_PHYS_REGS-1:0] Rrat_used_IN,
  output logic [LOG_PHYS:0]        Free_count_OUT,
  output logic                     Error_OUT
);

  localparam logic [NUM_PHYS_REGS-1:0] RESET_MASK = {NUM_PHYS_REGS{1'b1}} << NUM_ARCH_REGS;
  localparam logic [LOG_PHYS:0]        RESET_CNT  = (LOG_PHYS+1)'(NUM_PHYS_REGS - NUM_ARCH_REGS);
  localparam logic [LOG_PHYS:0]        PHYS_CNT   = (LOG_PHYS+1)'(NUM_PHYS_REGS);
  localparam logic [LOG_PHYS:0]        CNT_ONE    = (LOG_PHYS+1)'(1);

  logic [NUM_PHYS_REGS-1:0] free_mask, free_mask_nxt;
  logic [LOG_PHYS:0]        free_cnt, free_cnt_nxt;
  logic                     error_q, error_nxt;

  logic [LOG_PHYS-1:0]      first_idx;
  logic                     first_valid;
  logic [NUM_PHYS_REGS-1:0] free_sel;
  logic [NUM_PHYS_REGS-1:0] alloc_sel;
  logic [LOG_PHYS:0]        used_cnt;
  logic                     alloc_fire;
  logic                     free_busy;
  logic                     free_ok;
  logic                     free_err;

  find_first_set #(.WIDTH(NUM_PHYS_REGS)) u_ffs (
    .vec   (free_mask),
    .index (first_idx),
    .valid (first_valid)
  );

  assign Alloc_ready_OUT = (free_cnt != '0);
  assign Alloc_reg_OUT   = first_valid ? first_idx : '0;
  assign Free_count_OUT  = free_cnt;
  assign Error_OUT       = error_q;

  // One-hot decodes; an out-of-range Free_reg_IN yields an all-zero free_sel,
  // which is then treated exactly like freeing an already-free register.
  always_comb begin
    free_sel  = '0;
    alloc_sel = '0;
    used_cnt  = '0;
    for (int unsigned i = 0; i < NUM_PHYS_REGS; i++) begin
      free_sel[i]  = (Free_reg_IN == LOG_PHYS'(i));
      alloc_sel[i] = (first_idx == LOG_PHYS'(i));
      used_cnt     = used_cnt + (LOG_PHYS+1)'(Rrat_used_IN[i]);
    end
  end

  always_comb begin
    alloc_fire = Alloc_req_IN && Alloc_ready_OUT && !Flush_IN;
    free_busy  = |(free_sel & ~free_mask);
    free_ok    = Free_valid_IN && !Flush_IN && free_busy;
    free_err   = Free_valid_IN && !Flush_IN && !free_busy;

    free_mask_nxt = free_mask;
    free_cnt_nxt  = free_cnt;
    error_nxt     = error_q | free_err;

    if (Flush_IN) begin
      free_mask_nxt = ~Rrat_used_IN;
      free_cnt_nxt  = PHYS_CNT - used_cnt;
    end else begin
      // Allocation uses the pre-edge mask, so a same-cycle free is never granted.
      if (alloc_fire) begin
        free_mask_nxt = free_mask_nxt & ~alloc_sel;
        free_cnt_nxt  = free_cnt_nxt - CNT_ONE;
      end
      if (free_ok) begin
        free_mask_nxt = free_mask_nxt | free_sel;
        free_cnt_nxt  = free_cnt_nxt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      free_mask <= RESET_MASK;
      free_cnt  <= RESET_CNT;
      error_q   <= 1'b0;
    end else begin
      free_mask <= free_mask_nxt;
      free_cnt  <= free_cnt_nxt;
      error_q   <= error_nxt;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomised self-checking bench for phys_reg_free_list against a set-of-free-registers model.
module tb_phys_reg_free_list;

  localparam int NA = 32;
  localparam int NP = 64;

  logic          CLK;
  logic          RESET;
  logic          Alloc_req_IN;
  logic          Alloc_ready_OUT;
  logic [5:0]    Alloc_reg_OUT;
  logic          Free_valid_IN;
  logic [5:0]    Free_reg_IN;
  logic          Flush_IN;
  logic [NP-1:0] Rrat_used_IN;
  logic [6:0]    Free_count_OUT;
  logic          Error_OUT;

  int checks = 0;
  int errors = 0;

  bit m_free [NP];
  bit m_err;

  phys_reg_free_list #(.NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(NP)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .Alloc_req_IN    (Alloc_req_IN),
    .Alloc_ready_OUT (Alloc_ready_OUT),
    .Alloc_reg_OUT   (Alloc_reg_OUT),
    .Free_valid_IN   (Free_valid_IN),
    .Free_reg_IN     (Free_reg_IN),
    .Flush_IN        (Flush_IN),
    .Rrat_used_IN    (Rrat_used_IN),
    .Free_count_OUT  (Free_count_OUT),
    .Error_OUT       (Error_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NP; i++) n += int'(m_free[i]);
    return n;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < NP; i++) if (m_free[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_free[i] = (i >= NA);
    m_err = 1'b0;
  endtask

  task automatic idle();
    Alloc_req_IN  = 1'b0;
    Free_valid_IN = 1'b0;
    Free_reg_IN   = '0;
    Flush_IN      = 1'b0;
    Rrat_used_IN  = '0;
  endtask

  task automatic drive(input bit req, input bit fv, input logic [5:0] fr,
                       input bit fl, input logic [NP-1:0] rrat);
    @(negedge CLK);
    Alloc_req_IN  = req;
    Free_valid_IN = fv;
    Free_reg_IN   = fr;
    Flush_IN      = fl;
    Rrat_used_IN  = rrat;
    #1;
  endtask

  // Advance one edge and apply the free-list rules to the model using the driven inputs.
  task automatic tick();
    int  a;
    int  fr;
    bit  do_alloc;
    bit  do_free;
    @(posedge CLK);
    if (Flush_IN) begin
      for (int i = 0; i < NP; i++) m_free[i] = !Rrat_used_IN[i];
    end else begin
      a        = m_lowest();
      do_alloc = Alloc_req_IN && (m_count() > 0);
      fr       = int'(Free_reg_IN);
      do_free  = Free_valid_IN && (fr < NP) && !m_free[fr];
      if (Free_valid_IN && !do_free) m_err = 1'b1;
      if (do_alloc) m_free[a] = 1'b0;
      if (do_free)  m_free[fr] = 1'b1;
    end
    #1;
    idle();
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b0;
    idle();
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (Free_count_OUT !== 7'(m_count())) begin
      errors++; $display("FAIL reset_count: got %0d expected %0d", Free_count_OUT, m_count());
    end
    checks++;
    if (Alloc_ready_OUT !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", Alloc_ready_OUT);
    end
    checks++;
    if (Alloc_reg_OUT !== 6'(m_lowest())) begin
      errors++; $display("FAIL reset_reg: got %0d expected %0d", Alloc_reg_OUT, m_lowest());
    end
    checks++;
    if (Error_OUT !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b expected 0", Error_OUT);
    end
  endtask

  task automatic test_alloc_drain();
    apply_reset();
    for (int i = 0; i < NP - NA; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      checks++;
      if (Alloc_reg_OUT !== 6'(NA + i) || Alloc_reg_OUT !== 6'(m_lowest())) begin
        errors++; $display("FAIL drain_grant[%0d]: got %0d expected %0d", i, Alloc_reg_OUT, NA + i);
      end
      tick();
    end
    checks++;
    if (Alloc_ready_OUT !== 1'b0 || Free_count_OUT !== 7'(m_count())) begin
      errors++; $display("FAIL drain_empty: ready %b count %0d expected ready 0 count %0d",
                         Alloc_ready_OUT, Free_count_OUT, m_count());
    end
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    checks++;
    if (Error_OUT !== 1'b0 || Free_count_OUT !== 7'd0) begin
      errors++; $display("FAIL drain_extra_req: err %b count %0d expected err 0 count 0",
                         Error_OUT, Free_count_OUT);
    end
  endtask

  task automatic test_free_while_empty();
    drive(1'b1, 1'b1, 6'd40, 1'b0, '0);
    checks++;
    if (Alloc_ready_OUT !== 1'b0) begin
      errors++; $display("FAIL empty_free_nogrant: ready %b expected 0", Alloc_ready_OUT);
    end
    tick();
    checks++;
    if (Alloc_reg_OUT !== 6'd40 || Free_count_OUT !== 7'(m_count()) || m_count() != 1) begin
      errors++; $display("FAIL empty_free_next: reg %0d count %0d expected reg 40 count 1",
                         Alloc_reg_OUT, Free_count_OUT);
    end
  endtask

  task automatic test_double_free();
    logic [NP-1:0] rrat;
    apply_reset();
    drive(1'b0, 1'b1, 6'd50, 1'b0, '0);
    tick();
    checks++;
    if (Error_OUT !== m_err || Free_count_OUT !== 7'(m_count())) begin
      errors++; $display("FAIL double_free: err %b count %0d expected err %b count %0d",
                         Error_OUT, Free_count_OUT, m_err, m_count());
    end
    rrat = {32'h0, 32'hFFFF_FFFF};
    drive(1'b0, 1'b0, '0, 1'b1, rrat);
    tick();
    checks++;
    if (Error_OUT !== 1'b1) begin
      errors++; $display("FAIL err_sticky_flush: got %b expected 1", Error_OUT);
    end
  endtask

  task automatic test_flush();
    logic [NP-1:0] rrat;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      tick();
    end
    checks++;
    if (Free_count_OUT !== 7'(m_count())) begin
      errors++; $display("FAIL flush_pre_count: got %0d expected %0d", Free_count_OUT, m_count());
    end
    rrat = {32'h0, 32'hFFFF_FFFF};
    drive(1'b1, 1'b1, 6'd33, 1'b1, rrat);
    tick();
    checks++;
    if (Free_count_OUT !== 7'd32 || Alloc_reg_OUT !== 6'd32 || Error_OUT !== 1'b0) begin
      errors++; $display("FAIL flush_priority: count %0d reg %0d err %b expected 32 32 0",
                         Free_count_OUT, Alloc_reg_OUT, Error_OUT);
    end
  endtask

  task automatic test_random();
    bit            req;
    bit            fv;
    bit            fl;
    logic [5:0]    fr;
    logic [NP-1:0] rrat;
    int            start;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      req  = ($urandom % 3) != 0;
      fv   = ($urandom % 2) != 0;
      fl   = ($urandom % 40) == 0;
      rrat = {$urandom, $urandom};
      fr   = 6'($urandom % NP);
      // Early cycles return only registers the model holds as allocated.
      if (cyc < 250) begin
        start = int'(fr);
        for (int k = 0; k < NP; k++) begin
          if (!m_free[(start + k) % NP]) begin
            fr = 6'((start + k) % NP);
            break;
          end
        end
        if (m_count() == NP) fv = 1'b0;
      end
      drive(req, fv, fr, fl, rrat);
      checks++;
      if (Alloc_ready_OUT !== (m_count() != 0) || Alloc_reg_OUT !== 6'(m_lowest()) ||
          Free_count_OUT !== 7'(m_count())) begin
        errors++; $display("FAIL random[%0d]: ready %b reg %0d count %0d expected %b %0d %0d",
                           cyc, Alloc_ready_OUT, Alloc_reg_OUT, Free_count_OUT,
                           (m_count() != 0), m_lowest(), m_count());
      end
      tick();
      checks++;
      if (Error_OUT !== m_err) begin
        errors++; $display("FAIL random_err[%0d]: got %b expected %b", cyc, Error_OUT, m_err);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      tick();
    end
    drive(1'b1, 1'b1, 6'd33, 1'b0, '0);
    #1;
    RESET = 1'b0;
    model_reset();
    #1;
    checks++;
    if (Free_count_OUT !== 7'(m_count()) || Alloc_ready_OUT !== 1'b1 ||
        Alloc_reg_OUT !== 6'(m_lowest()) || Error_OUT !== 1'b0) begin
      errors++; $display("FAIL async_reset: count %0d ready %b reg %0d err %b expected 32 1 32 0",
                         Free_count_OUT, Alloc_ready_OUT, Alloc_reg_OUT, Error_OUT);
    end
    @(negedge CLK);
    idle();
    RESET = 1'b1;
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    checks++;
    if (Free_count_OUT !== 7'(m_count()) || Alloc_reg_OUT !== 6'(m_lowest())) begin
      errors++; $display("FAIL post_reset_alloc: count %0d reg %0d expected %0d %0d",
                         Free_count_OUT, Alloc_reg_OUT, m_count(), m_lowest());
    end
  endtask

  initial begin
    RESET = 1'b0;
    idle();
    model_reset();
    test_reset();
    test_alloc_drain();
    test_free_while_empty();
    test_double_free();
    test_flush();
    test_random();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
